// File: rtl/rv32_uart_pkg.sv
// Shared definitions for the peripheral-bus UART responder: register offsets, STATUS bit layout
// and the state encoding common to the transmit and receive engines.
package rv32_uart_pkg;

  localparam logic [1:0] RegTxData  = 2'd0;
  localparam logic [1:0] RegRxData  = 2'd1;
  localparam logic [1:0] RegStatus  = 2'd2;
  localparam logic [1:0] RegBaudDiv = 2'd3;

  localparam int unsigned StatTxFull   = 0;
  localparam int unsigned StatTxEmpty  = 1;
  localparam int unsigned StatTxBusy   = 2;
  localparam int unsigned StatRxValid  = 3;
  localparam int unsigned StatRxOvr    = 4;
  localparam int unsigned StatTxOvf    = 5;
  localparam int unsigned StatFrameErr = 6;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_t;

  // Divisors below 3 leave no room for a mid-bit sample point.
  function automatic logic [15:0] baud_clamp(input logic [15:0] v);
    return (v < 16'd3) ? 16'd3 : v;
  endfunction

endpackage

// File: rtl/rv32_uart_if.sv
// Core-side load/store port of the UART responder.
interface rv32_uart_if;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/rv32_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module rv32_uart_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{PtrW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{PtrW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/rv32_uart_responder.sv
// Memory-mapped 8N1 UART target: register file, FIFO-fed transmitter and a receiver with a
// single-entry holding register.
module rv32_uart_responder
  import rv32_uart_pkg::*;
#(
  parameter int unsigned ClkHz   = 50_000_000,
  parameter int unsigned Baud    = 115_200,
  parameter int unsigned TxDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  rv32_uart_if.slave  bus,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);
  localparam logic [15:0] BaudDivRst = 16'(ClkHz / Baud - 1);

  logic [1:0]  reg_sel;
  logic        wr_tx, wr_stat, rx_pop;
  logic [2:0]  flag_clr;
  logic [15:0] baud_q, baud_d, baud_new;

  logic        fifo_full, fifo_empty, tx_pop;
  logic [7:0]  fifo_dout;

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_cnt_zero;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_cnt_zero, rx_done, ferr_set, ovr_set, ovf_set;

  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        ovr_q, ovr_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic [6:0]  status;
  logic [31:0] rdata;
  logic        unused_bus;

  assign unused_bus = ^{bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:16],
                        bus.mem_we[3:2]};

  assign reg_sel  = bus.mem_addr[3:2];
  assign wr_tx    = bus.mem_we[0] && (reg_sel == RegTxData);
  assign wr_stat  = bus.mem_we[0] && (reg_sel == RegStatus);
  assign rx_pop   = wr_stat && bus.mem_wdata[StatRxValid];
  assign flag_clr = wr_stat ? bus.mem_wdata[StatFrameErr:StatRxOvr] : 3'b000;

  always_comb begin
    baud_new = baud_q;
    if (reg_sel == RegBaudDiv) begin
      if (bus.mem_we[0]) baud_new[7:0]  = bus.mem_wdata[7:0];
      if (bus.mem_we[1]) baud_new[15:8] = bus.mem_wdata[15:8];
    end
    baud_d = baud_clamp(baud_new);
  end

  rv32_uart_fifo #(
    .Depth (TxDepth),
    .Width (8)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_n_i),
    .push_i  (wr_tx),
    .data_i  (bus.mem_wdata[7:0]),
    .pop_i   (tx_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_dout)
  );

  // Baud counters reload from baud_q only at bit boundaries, so divisor writes land cleanly.
  assign tx_cnt_zero = (tx_cnt_q == 16'd0);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_zero ? baud_q : tx_cnt_q - 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = baud_q;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_zero) begin
          tx_bit_d   = 3'd0;
          tx_state_d = StData;
        end
      end
      StData: begin
        if (tx_cnt_zero) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = StStop;
        end
      end
      StStop: begin
        if (tx_cnt_zero) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_dout;
            tx_state_d = StStart;
          end else begin
            tx_state_d = StIdle;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase

    case (tx_state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign rx_cnt_zero = (rx_cnt_q == 16'd0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_zero ? baud_q : rx_cnt_q - 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = baud_q >> 1;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_zero) begin
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_cnt_zero) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
        end
      end
      StStop: begin
        if (rx_cnt_zero) begin
          rx_done    = rx_sync_q;
          ferr_set   = ~rx_sync_q;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // A delivery that coincides with a pop replaces the held byte instead of overrunning.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    ovr_set    = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rx_pop) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
    ovf_set = wr_tx && fifo_full && !tx_pop;
    ovr_d   = ovr_set  | (ovr_q  & ~flag_clr[0]);
    ovf_d   = ovf_set  | (ovf_q  & ~flag_clr[1]);
    ferr_d  = ferr_set | (ferr_q & ~flag_clr[2]);
  end

  always_comb begin
    status               = '0;
    status[StatTxFull]   = fifo_full;
    status[StatTxEmpty]  = fifo_empty;
    status[StatTxBusy]   = (tx_state_q != StIdle);
    status[StatRxValid]  = rx_valid_q;
    status[StatRxOvr]    = ovr_q;
    status[StatTxOvf]    = ovf_q;
    status[StatFrameErr] = ferr_q;
    unique case (reg_sel)
      RegRxData:  rdata = {23'd0, rx_valid_q, rx_byte_q};
      RegStatus:  rdata = {25'd0, status};
      RegBaudDiv: rdata = {16'd0, baud_q};
      default:    rdata = 32'd0;
    endcase
  end

  assign bus.mem_rdata = rdata;
  assign uart_tx_o     = tx_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      baud_q     <= BaudDivRst;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      ovr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      ovr_q      <= ovr_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
